// File: rtl/bram_instruction_fetcher.sv
// Streams a contiguous (optionally wrapping) BRAM word range into a small ready/valid output FIFO.
// Optional macro FETCH_LOOP_EN: restart at start_addr after end_addr until stop or reset.
module bram_instruction_fetcher #(
  parameter int unsigned BRAM_WIDTH = 32,
  parameter int unsigned BRAM_DEPTH = 65536,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW = $clog2(BRAM_DEPTH)
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [AW-1:0]         start_addr,
  input  logic [AW-1:0]         end_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [AW-1:0]         bram_addr,
  input  logic [BRAM_WIDTH-1:0] bram_dout,
  output logic [BRAM_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned CW   = PW + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_bram_en;
  logic                  w_bram_en_nxt;
  logic [AW-1:0]         r_bram_addr;
  logic [AW-1:0]         w_bram_addr_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic [AW-1:0]         r_end_addr;
`ifdef FETCH_LOOP_EN
  logic [AW-1:0]         r_start_addr;
`endif

  logic                  r_rd_vld;
  logic [BRAM_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CNTW-1:0]       r_count;

  logic                  w_flush;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_room;
  logic                  w_last_is_end;
  logic [CW-1:0]         w_pending;
  logic [AW-1:0]         w_addr_inc;
  logic [AW-1:0]         w_addr_next;

  assign w_flush  = stop && (r_state != S_IDLE);
  assign w_accept = start && !stop && (r_state == S_IDLE);
  assign w_push   = r_rd_vld;
  assign w_pop    = (r_count != '0) && m_ready;

  // Words already buffered plus reads still landing; a pop this cycle frees a slot.
  assign w_pending = CW'(r_count) + CW'(r_rd_vld) + CW'(r_bram_en) - CW'(w_pop);
  assign w_room    = w_pending < CW'(FIFO_DEPTH);

  assign w_addr_inc    = (r_bram_addr == AW'(BRAM_DEPTH - 1)) ? '0 : r_bram_addr + AW'(1);
  assign w_last_is_end = (r_bram_addr == r_end_addr);
`ifdef FETCH_LOOP_EN
  assign w_addr_next = w_last_is_end ? r_start_addr : w_addr_inc;
`else
  assign w_addr_next = w_addr_inc;
`endif

  // Next-state and registered-output decode; r_bram_addr is always the last issued address.
  always_comb begin
    w_state_nxt     = r_state;
    w_bram_en_nxt   = 1'b0;
    w_bram_addr_nxt = r_bram_addr;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt     = S_FETCH;
          w_bram_en_nxt   = 1'b1;
          w_bram_addr_nxt = start_addr;
        end
      end
      S_FETCH: begin
`ifdef FETCH_LOOP_EN
        if (w_room) begin
          w_bram_en_nxt   = 1'b1;
          w_bram_addr_nxt = w_addr_next;
        end
`else
        if (r_bram_en && w_last_is_end) begin
          w_state_nxt = S_DRAIN;
        end else if (w_room) begin
          w_bram_en_nxt   = 1'b1;
          w_bram_addr_nxt = w_addr_next;
        end
`endif
      end
      S_DRAIN: begin
        if (!r_bram_en && !r_rd_vld && (r_count == '0)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_flush) begin
      w_state_nxt   = S_IDLE;
      w_bram_en_nxt = 1'b0;
      w_done_nxt    = 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state     <= S_IDLE;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      r_done      <= 1'b0;
      r_end_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bram_en   <= w_bram_en_nxt;
      r_bram_addr <= w_bram_addr_nxt;
      r_done      <= w_done_nxt;
      if (w_accept) r_end_addr <= end_addr;
    end
  end

`ifdef FETCH_LOOP_EN
  always_ff @(posedge in_clk) begin
    if (in_rst) r_start_addr <= '0;
    else if (w_accept) r_start_addr <= start_addr;
  end
`endif

  // Read-data capture and FIFO bookkeeping; stop or reset drops everything in flight.
  always_ff @(posedge in_clk) begin
    if (in_rst || w_flush) begin
      r_rd_vld <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_vld <= r_bram_en;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

  always_ff @(posedge in_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bram_dout;
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign bram_en   = r_bram_en;
  assign bram_addr = r_bram_addr;
  assign m_valid   = (r_count != '0);
  assign m_data    = m_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_bram_instruction_fetcher.sv
// Scoreboard bench for bram_instruction_fetcher: expected words are queued at launch, a monitor pops on each transfer.
module tb_bram_instruction_fetcher;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 65536;
  localparam int unsigned FD = 4;
  localparam int unsigned AW = 16;

  logic          in_clk = 1'b0;
  logic          in_rst;
  logic          start;
  logic          stop;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic          busy;
  logic          done;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [W-1:0]  bram_dout = '0;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int en_cnt = 0;
  int xfer_cnt = 0;
  logic [15:0]  salt = 16'h0;
  logic [W-1:0] exp_q[$];
  logic         hold_prev = 1'b0;
  logic [W-1:0] hold_data = '0;

  always #5 in_clk = ~in_clk;

  bram_instruction_fetcher #(
    .BRAM_WIDTH(W),
    .BRAM_DEPTH(D),
    .FIFO_DEPTH(FD)
  ) dut (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .start     (start),
    .stop      (stop),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .busy      (busy),
    .done      (done),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  function automatic logic [W-1:0] word_at(input logic [AW-1:0] a);
    return {salt, a};
  endfunction

  // One-cycle-latency BRAM model.
  always @(posedge in_clk) if (bram_en) bram_dout <= word_at(bram_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, done/busy coincidence, read-enable count.
  always @(negedge in_clk) begin
    if (!in_rst) begin
      if (bram_en) en_cnt++;
      if (done) begin
        done_cnt++;
        check("busy_with_done", busy, 0);
      end
      if (hold_prev && m_valid) check("stall_stable", m_data, hold_data);
      if (m_valid && m_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", m_data);
        end else begin
          check("word", m_data, exp_q.pop_front());
        end
      end
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] e);
    int n;
    n = int'(AW'(e - s)) + 1;
    for (int i = 0; i < n; i++) exp_q.push_back(word_at(AW'(int'(s) + i)));
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input int ready_pct, input bit poke);
    for (int k = 0; k < max_cyc && busy; k++) begin
      m_ready = ($urandom_range(99) < ready_pct);
      start   = poke && ($urandom_range(7) == 0);
      if (start) begin
        start_addr = AW'($urandom);
        end_addr   = AW'($urandom);
      end
      tick();
      start = 1'b0;
    end
    check("idle_timeout", busy, 0);
    m_ready = 1'b1;
  endtask

  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] e, input int ready_pct, input bit poke);
    int d0;
    d0 = done_cnt;
    launch(s, e);
    wait_idle(2000, ready_pct, poke);
    tick();
    check("done_once", done_cnt, d0 + 1);
    check("all_words", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int x0;
    int k;
    in_rst = 1'b1; start = 1'b0; stop = 1'b0; m_ready = 1'b1;
    start_addr = '0; end_addr = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    in_rst = 1'b0;
    tick();

`ifdef FETCH_LOOP_EN
    salt = 16'h0;
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) exp_q.push_back(word_at((i % 2 == 0) ? 16'd5 : 16'd6));
    start_addr = 16'd5; end_addr = 16'd6; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin tick(); k++; end
    m_ready = 1'b0;
    check("loop_words", exp_q.size(), 0);
    check("loop_busy", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("loop_stop_busy", busy, 0);
    check("loop_stop_valid", m_valid, 0);
    check("loop_no_done", done_cnt, d0);
    m_ready = 1'b1;
`else
    // Basic run: exact first-word latency and one word per cycle.
    salt = 16'h0;
    d0 = done_cnt;
    launch(16'h0010, 16'h0013);
    check("lat_e0_valid", m_valid, 0);
    tick();
    check("lat_e1_valid", m_valid, 0);
    tick();
    check("lat_e2_valid", m_valid, 1);
    check("lat_e2_data", m_data, 32'h10);
    x0 = xfer_cnt;
    repeat (4) tick();
    check("back_to_back", xfer_cnt - x0, 4);
    wait_idle(100, 100, 0);
    tick();
    check("basic_done", done_cnt, d0 + 1);
    check("basic_words", exp_q.size(), 0);

    // Address wrap and single-word range.
    salt = 16'($urandom);
    run(16'hFFFE, 16'h0001, 60, 0);
    run(16'h1234, 16'h1234, 100, 0);

    // Backpressure: only FIFO_DEPTH reads may be issued.
    salt = 16'($urandom);
    m_ready = 1'b0;
    en_cnt = 0;
    d0 = done_cnt;
    launch(16'd0, 16'd9);
    repeat (19) tick();
    check("bp_en_count", en_cnt, FD);
    check("bp_valid", m_valid, 1);
    wait_idle(500, 100, 0);
    tick();
    check("bp_done", done_cnt, d0 + 1);
    check("bp_words", exp_q.size(), 0);

    // Abort after the third word, then restart elsewhere.
    salt = 16'h0;
    x0 = xfer_cnt;
    launch(16'd0, 16'd99);
    k = 0;
    while (xfer_cnt - x0 < 3 && k < 100) begin tick(); k++; end
    m_ready = 1'b0;
    stop = 1'b1;
    d0 = done_cnt;
    tick();
    stop = 1'b0;
    exp_q.delete();
    check("stop_valid", m_valid, 0);
    check("stop_busy", busy, 0);
    repeat (5) tick();
    check("stop_no_done", done_cnt, d0);
    check("stop_idle_valid", m_valid, 0);
    m_ready = 1'b1;
    run(16'h0200, 16'h0203, 100, 0);

    // Stop wins over a simultaneous start.
    start_addr = 16'h0040; end_addr = 16'h0041;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("stop_over_start_busy", busy, 0);
    tick();
    check("stop_over_start_valid", m_valid, 0);

    // Reset mid-run.
    salt = 16'($urandom);
    launch(16'd0, 16'd50);
    repeat (6) tick();
    in_rst = 1'b1;
    tick();
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_bram_en", bram_en, 0);
    check("mrst_bram_addr", bram_addr, 0);
    check("mrst_m_valid", m_valid, 0);
    check("mrst_m_data", m_data, 0);
    in_rst = 1'b0;
    exp_q.delete();
    x0 = xfer_cnt;
    repeat (10) tick();
    check("mrst_no_emit", xfer_cnt, x0);
    check("mrst_idle", busy, 0);

    // Randomised ranges with random backpressure and ignored starts while busy.
    for (int r = 0; r < 25; r++) begin
      logic [AW-1:0] s;
      logic [AW-1:0] e;
      salt = 16'($urandom);
      s = AW'($urandom);
      if ($urandom_range(3) == 0) s = AW'(16'hFFF8 + $urandom_range(7));
      e = AW'(s + AW'($urandom_range(11)));
      run(s, e, $urandom_range(30, 100), 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
